// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared types and constants for the SPI register bank
package spi_regbank_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CMD    = 2'd1,
      DATA   = 2'd2,
      COMMIT = 2'd3
   } state_t;

   localparam logic RD = 1'b1;
   localparam logic WR = 1'b0;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 3-flop pin synchroniser with rise/fall detect
module spi_pin_sync (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   // Reset flushes the chain to the live pin level so a line already low
   // when reset releases is not mistaken for a fresh edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sr <= {3{pin}};
      end else begin
         sr <= {sr[1:0], pin};
      end
   end

   assign level = sr[1];
   assign rise  = sr[1] & ~sr[2];
   assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - SPI slave register bank with burst access and atomic commit
module spi_regbank
   import spi_regbank_pkg::*;
#(
   parameter int NUM_REGS = 6,
   parameter int NUM_RO   = 2,
   parameter int DATA_W   = 10,
   parameter int ADDR_W   = 3,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       SCK,
   input  logic                       CS,
   input  logic                       COPI,
   output logic                       CIPO,
   output logic                       cipo_oe,
   input  logic [NUM_RO*DATA_W-1:0]   status_in,
   output logic [NUM_REGS*DATA_W-1:0] regs_out,
   output logic                       commit_pulse,
   output logic                       frame_err,
   input  logic                       clr_err
);

   localparam int CNT_W    = $clog2(DATA_W + ADDR_W + 1);
   localparam int LAST_PTR = NUM_REGS + NUM_RO - 1;

   logic sck_rise, sck_fall;
   logic cs_level, cs_rise, cs_fall;
   logic copi_level;

   spi_pin_sync u_sync_sck (
      .clk   (clk),
      .rst   (rst),
      .pin   (SCK),
      .level (),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   spi_pin_sync u_sync_cs (
      .clk   (clk),
      .rst   (rst),
      .pin   (CS),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_pin_sync u_sync_copi (
      .clk   (clk),
      .rst   (rst),
      .pin   (COPI),
      .level (copi_level),
      .rise  (),
      .fall  ()
   );

   state_t              state;
   logic [CNT_W-1:0]    bit_cnt;
   logic [ADDR_W:0]     cmd_sr;
   logic                rw;
   logic [ADDR_W-1:0]   ptr;
   logic [DATA_W-1:0]   shift_in;
   logic [DATA_W-1:0]   shift_out;
   logic                word_done;
   logic [DATA_W-1:0]   active [NUM_REGS];
   logic [DATA_W-1:0]   shadow [NUM_REGS];

   logic [ADDR_W:0]     cmd_next;
   logic [DATA_W-1:0]   word_next;
   logic [DATA_W-1:0]   rd_word;
   logic [ADDR_W-1:0]   ptr_next;

   assign cmd_next  = {cmd_sr[ADDR_W-1:0], copi_level};
   assign word_next = {shift_in[DATA_W-2:0], copi_level};
   assign ptr_next  = (int'(ptr) == LAST_PTR) ? '0 : ptr + ADDR_W'(1);

   // Read source: active register, then status words, zero beyond the map
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (int'(ptr) == k) rd_word = active[k];
      end
      for (int k = 0; k < NUM_RO; k++) begin
         if (int'(ptr) == NUM_REGS + k) rd_word = status_in[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         cmd_sr       <= '0;
         rw           <= WR;
         ptr          <= '0;
         shift_in     <= '0;
         shift_out    <= '0;
         word_done    <= 1'b0;
         CIPO         <= 1'b0;
         cipo_oe      <= 1'b0;
         commit_pulse <= 1'b0;
         frame_err    <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            active[k] <= RESET_VAL[k*DATA_W +: DATA_W];
            shadow[k] <= RESET_VAL[k*DATA_W +: DATA_W];
         end
      end else begin
         commit_pulse <= 1'b0;
         cipo_oe      <= ~cs_level;
         if (clr_err) frame_err <= 1'b0;

         if (cs_rise) begin
            state <= COMMIT;
            CIPO  <= 1'b0;
            if (state == DATA && rw == WR && word_done && bit_cnt == '0) begin
               for (int k = 0; k < NUM_REGS; k++) active[k] <= shadow[k];
               commit_pulse <= 1'b1;
            end
            // An incomplete frame is discarded whole; the error set overrides clr_err
            if (state == CMD || (state == DATA && bit_cnt != '0)) frame_err <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state     <= CMD;
                     bit_cnt   <= '0;
                     word_done <= 1'b0;
                     for (int k = 0; k < NUM_REGS; k++) shadow[k] <= active[k];
                  end
               end
               CMD: begin
                  if (sck_rise) begin
                     cmd_sr <= cmd_next;
                     if (bit_cnt == CNT_W'(ADDR_W)) begin
                        state   <= DATA;
                        rw      <= cmd_next[ADDR_W];
                        ptr     <= cmd_next[ADDR_W-1:0];
                        bit_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end
               end
               DATA: begin
                  if (sck_rise) begin
                     shift_in <= word_next;
                     if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        if (rw == WR) begin
                           for (int k = 0; k < NUM_REGS; k++) begin
                              if (int'(ptr) == k) shadow[k] <= word_next;
                           end
                        end
                        ptr       <= ptr_next;
                        bit_cnt   <= '0;
                        word_done <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end else if (sck_fall && rw == RD) begin
                     // bit_cnt is zero only on the fall right after a word boundary
                     if (bit_cnt == '0) begin
                        shift_out <= rd_word;
                        CIPO      <= rd_word[DATA_W-1];
                     end else begin
                        shift_out <= {shift_out[DATA_W-2:0], 1'b0};
                        CIPO      <= shift_out[DATA_W-2];
                     end
                  end
               end
               COMMIT: begin
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign regs_out[g*DATA_W +: DATA_W] = active[g];
   end

endmodule
